// File: rtl/byte_serial_adder.sv
// byte_serial_adder: wide a+b+cin computed one byte per clock through a single 8-bit CLA; BYTE_SERIAL_ADDER_OVF_EN adds signed overflow.
module Carry_Look_Ahead_Adder_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       c0,
  output logic [7:0] sum,
  output logic       c8
);
  logic [7:0] g, p;
  logic t;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    sum = '0;
    t = c0;
    for (int i = 0; i < 8; i++) begin
      sum[i] = p[i] ^ t;
      t = g[i] | (p[i] & t);
    end
    c8 = t;
  end
endmodule

module byte_serial_adder #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);
  localparam int W = 8 * NBYTES;
  localparam int CW = $clog2(NBYTES);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [W-1:0] a_sr, b_sr;
  logic carry, last, accept, cla_c8;
  logic [7:0] cla_sum;
  Carry_Look_Ahead_Adder_8bit u_cla (
    .a   (a_sr[7:0]),
    .b   (b_sr[7:0]),
    .c0  (carry),
    .sum (cla_sum),
    .c8  (cla_c8)
  );
  assign last = cnt == CW'(NBYTES - 1);
  assign accept = state == IDLE && in_valid;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    if (accept) state_nx = RUN;
    if (state == RUN && last) state_nx = DONE;
    if (state == DONE && out_ready) state_nx = IDLE;
  end
  // operands shift right so the CLA always sees the current byte in bits [7:0]
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      carry <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      carry <= cin;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
    end else if (state == RUN) begin
      sum[cnt*8 +: 8] <= cla_sum;
      carry <= cla_c8;
      a_sr <= a_sr >> 8;
      b_sr <= b_sr >> 8;
      if (last) cout <= cla_c8;
      else cnt <= cnt + 1'b1;
    end
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ovf <= 1'b0;
    else if (accept) ovf <= 1'b0;
    else if (state == RUN && last) ovf <= (a_sr[7] == b_sr[7]) && (cla_sum[7] != a_sr[7]);
`else
  assign ovf = 1'b0;
`endif
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder: directed and random checks of byte_serial_adder with NBYTES=4.
module tb_byte_serial_adder;
  localparam int NB = 4;
  localparam int W = 8 * NB;
`ifdef BYTE_SERIAL_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  typedef logic [W:0] vt;
  logic clk, rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf;
  logic [W-1:0] a, b, sum;
  int cmp = 0;
  int errs = 0;
  byte_serial_adder #(.NBYTES(NB)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input vt got, input vt exp);
    cmp++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input int gap, output vt res, output logic ov);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin tick; n++; end
    a = x; b = y; cin = ci; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin tick; n++; end
    chk("op_out_valid", vt'(out_valid), vt'(1));
    repeat (gap) tick;
    res = {cout, sum};
    ov = ovf;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask
  initial begin
    vt r, e;
    logic ov, eo;
    logic [W-1:0] x, y;
    logic ci;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    chk("rst_in_ready", vt'(in_ready), vt'(1));
    chk("rst_out_valid", vt'(out_valid), vt'(0));
    chk("rst_sum", vt'(sum), vt'(0));
    chk("rst_cout", vt'(cout), vt'(0));
    chk("rst_ovf", vt'(ovf), vt'(0));
    rst_n = 1'b1;
    tick;
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("lat_in_ready_low", vt'(in_ready), vt'(0));
    repeat (3) tick;
    chk("lat_not_yet", vt'(out_valid), vt'(0));
    tick;
    chk("lat_valid", vt'(out_valid), vt'(1));
    chk("lat_sum", vt'(sum), vt'(32'h0000_0100));
    chk("lat_cout", vt'(cout), vt'(0));
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    chk("hs_valid_low", vt'(out_valid), vt'(0));
    chk("hs_in_ready", vt'(in_ready), vt'(1));
    chk("idle_sum_held", vt'(sum), vt'(32'h0000_0100));
    run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0, r, ov);
    chk("carry_all_bytes", r, {1'b1, 32'h0000_0000});
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1, r, ov);
    chk("ovf_pos_sum", r, {1'b0, 32'h8000_0000});
    chk("ovf_pos", vt'(ov), vt'(OVF_EN));
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, r, ov);
    chk("ovf_none_sum", r, {1'b1, 32'h0000_0000});
    chk("ovf_none", vt'(ov), vt'(0));
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b0; in_valid = 1'b1;
    tick;
    a = 32'h0000_000A; b = 32'h0000_000B;
    repeat (4) tick;
    chk("bp_valid", vt'(out_valid), vt'(1));
    for (int i = 0; i < 5; i++) begin
      chk("bp_sum_stable", vt'(sum), vt'(32'h2345_6789));
      chk("bp_in_ready_low", vt'(in_ready), vt'(0));
      tick;
    end
    out_ready = 1'b1;
    tick;
    chk("bp_after_hs_valid", vt'(out_valid), vt'(0));
    chk("bp_after_hs_ready", vt'(in_ready), vt'(1));
    tick;
    in_valid = 1'b0;
    chk("bp_new_accepted", vt'(in_ready), vt'(0));
    repeat (3) tick;
    chk("run_out_ready_ignored", vt'(out_valid), vt'(0));
    tick;
    chk("bp_new_valid", vt'(out_valid), vt'(1));
    chk("bp_new_sum", {cout, sum}, vt'(32'h0000_0015));
    tick;
    out_ready = 1'b0;
    chk("bp_new_hs", vt'(out_valid), vt'(0));
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b0; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    chk("mid_partial", vt'(sum), vt'(32'h0000_0002));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", vt'(out_valid), vt'(0));
    chk("mid_rst_sum", vt'(sum), vt'(0));
    chk("mid_rst_in_ready", vt'(in_ready), vt'(1));
    #2;
    rst_n = 1'b1;
    tick;
    run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0, r, ov);
    chk("post_rst_sum", r, {1'b1, 32'h0000_0000});
    chk("post_rst_ovf", vt'(ov), vt'(OVF_EN));
    for (int i = 0; i < 300; i++) begin
      x = $urandom;
      y = $urandom;
      ci = 1'($urandom_range(0, 1));
      e = vt'(x) + vt'(y) + vt'(ci);
      run_op(x, y, ci, $urandom_range(0, 3), r, ov);
      chk("rand_sum", r, e);
      eo = OVF_EN && (x[W-1] == y[W-1]) && (e[W-1] != x[W-1]);
      chk("rand_ovf", vt'(ov), vt'(eo));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
